ov7670_frame_writer: RTL and testbench

OV7670_FRAME_WRITER -- requirements
Module: ov7670_frame_writer

---
 rtl/ov7670_frame_writer.sv | 195 +++++++++++++++++++
 tb/tb_ov7670_frame_writer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_writer.sv
// ---------------------------------------------------------------------------
// ov7670_frame_writer
//
// Writes RGB444 pixels from the OV7670 capture stage into one half of a
// double-buffered frame store and hands completed frames to a consumer.
// After reset the block waits for one frame_done so that it always starts
// on a frame boundary. A frame is only handed over when exactly
// H_PIXELS*V_LINES pixels were seen. If the consumer still holds the
// other bank, the finished frame is dropped and the same bank is rewritten.
//
// Optional feature (macro OV7670_DECIMATE_EN): keep only pixels on even
// columns and even lines, giving a quarter-size image. The completeness
// check still uses the raw pixel count.
//
// Parameters
//   H_PIXELS    active pixels per line
//   V_LINES     lines per frame
//   ADDR_W      width of mem_addr
//
// Ports
//   pclk         in   pixel clock; all logic runs on its rising edge
//   rst_n        in   asynchronous active-low reset
//   pixel_in     in   12-bit RGB444 pixel
//   pixel_valid  in   pixel_in valid this cycle
//   frame_done   in   single-cycle end-of-frame pulse
//   mem_we       out  frame-buffer write strobe (registered)
//   mem_bank     out  bank addressed by mem_we
//   mem_addr     out  pixel address within mem_bank
//   mem_wdata    out  pixel data written
//   frame_ready  out  a complete frame is held in ready_bank
//   ready_bank   out  bank holding the completed frame
//   frame_ack    in   consumer releases ready_bank
//   frame_err    out  sticky flag: a short or overlong frame was seen
//   drop_cnt     out  saturating count of complete frames dropped
// ---------------------------------------------------------------------------
module ov7670_frame_writer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic [11:0]       pixel_in,
  input  logic              pixel_valid,
  input  logic              frame_done,
  output logic              mem_we,
  output logic              mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [11:0]       mem_wdata,
  output logic              frame_ready,
  output logic              ready_bank,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic [7:0]        drop_cnt
);

  localparam int TOTAL = H_PIXELS * V_LINES;
  // One extra code above TOTAL marks "overlong". The counter saturates there
  // so a runaway frame can never wrap back to a count that looks complete.
  localparam int CNT_W = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(TOTAL + 1);

  typedef enum logic {SYNC, WRITE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  pix_cnt_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              other_busy;
  logic              in_range;
  logic              keep;
  logic              ack_eff;
  logic              busy_eff;
  logic              complete;
  logic              pos_kept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_OVER) ? v : v + 1'b1;
  endfunction

`ifdef OV7670_DECIMATE_EN
  localparam int COL_W = $clog2(H_PIXELS + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_PIXELS - 1);

  // Column/line of the pixel that pix_cnt currently points at.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign pos_kept = ~col[0] & ~row[0];
`else
  assign pos_kept = 1'b1;
`endif

  always_comb begin
    in_range    = (pix_cnt < CNT_FULL);
    keep        = pixel_valid & in_range & pos_kept;
    // A pixel arriving together with frame_done counts toward this frame.
    pix_cnt_nxt = pixel_valid ? cnt_inc(pix_cnt) : pix_cnt;
    complete    = (pix_cnt_nxt == CNT_FULL);
    // An ack in the same cycle as a completing frame_done frees the bank first.
    ack_eff     = frame_ack & frame_ready;
    busy_eff    = other_busy & ~ack_eff;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      mem_we      <= 1'b0;
      mem_bank    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wr_bank     <= 1'b0;
      other_busy  <= 1'b0;
      frame_ready <= 1'b0;
      ready_bank  <= 1'b0;
      frame_err   <= 1'b0;
      drop_cnt    <= '0;
      pix_cnt     <= '0;
      wr_addr     <= '0;
`ifdef OV7670_DECIMATE_EN
      col         <= '0;
      row         <= '0;
`endif
    end else begin
      mem_we   <= 1'b0;
      mem_bank <= wr_bank;

      if (ack_eff) begin
        frame_ready <= 1'b0;
        other_busy  <= 1'b0;
      end

      case (state)
        SYNC: begin
          if (frame_done) state <= WRITE;
        end

        WRITE: begin
          if (pixel_valid) begin
            pix_cnt <= pix_cnt_nxt;
            if (!in_range) frame_err <= 1'b1;
`ifdef OV7670_DECIMATE_EN
            if (in_range) begin
              if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
`endif
          end

          if (keep) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= pixel_in;
            wr_addr   <= wr_addr + 1'b1;
          end

          if (frame_done) begin
            pix_cnt <= '0;
            wr_addr <= '0;
`ifdef OV7670_DECIMATE_EN
            col     <= '0;
            row     <= '0;
`endif
            if (complete) begin
              if (!busy_eff) begin
                wr_bank     <= ~wr_bank;
                ready_bank  <= wr_bank;
                frame_ready <= 1'b1;
                other_busy  <= 1'b1;
              end else begin
                drop_cnt <= sat_inc8(drop_cnt);
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_frame_writer.sv
module tb_ov7670_frame_writer;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 8;
  localparam int TOTAL = H * V;
`ifdef OV7670_DECIMATE_EN
  localparam int NW = (H / 2) * (V / 2);
`else
  localparam int NW = TOTAL;
`endif

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [11:0]   pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_done = 1'b0;
  logic          frame_ack = 1'b0;
  logic          mem_we;
  logic          mem_bank;
  logic [AW-1:0] mem_addr;
  logic [11:0]   mem_wdata;
  logic          frame_ready;
  logic          ready_bank;
  logic          frame_err;
  logic [7:0]    drop_cnt;

  ov7670_frame_writer #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .pclk(pclk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_done(frame_done), .mem_we(mem_we), .mem_bank(mem_bank),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .frame_ready(frame_ready),
    .ready_bank(ready_bank), .frame_ack(frame_ack), .frame_err(frame_err),
    .drop_cnt(drop_cnt)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame-level view: whether we are synchronised, how many pixels this frame
  // has seen, and which banks are owned by writer/consumer.
  bit m_synced;
  int m_cnt;
  bit m_err, m_wb, m_busy, m_rdy, m_rb;
  int m_drop;
  bit e_we, e_mb;
  int e_addr, e_data;

  function automatic bit pix_kept(input int idx);
`ifdef OV7670_DECIMATE_EN
    return ((idx % H) % 2 == 0) && ((idx / H) % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int pix_addr(input int idx);
`ifdef OV7670_DECIMATE_EN
    return (idx / H / 2) * (H / 2) + (idx % H) / 2;
`else
    return idx;
`endif
  endfunction

  task automatic model_reset();
    m_synced = 0; m_cnt = 0; m_err = 0; m_wb = 0; m_busy = 0;
    m_rdy = 0; m_rb = 0; m_drop = 0;
    e_we = 0; e_mb = 0; e_addr = 0; e_data = 0;
  endtask

  task automatic model_step();
    e_mb = m_wb;
    e_we = 0;
    if (frame_ack && m_rdy) begin
      m_rdy = 0;
      m_busy = 0;
    end
    if (!m_synced) begin
      if (frame_done) m_synced = 1;
    end else begin
      if (pixel_valid) begin
        if (m_cnt < TOTAL) begin
          if (pix_kept(m_cnt)) begin
            e_we = 1;
            e_addr = pix_addr(m_cnt);
            e_data = int'(pixel_in);
          end
        end else begin
          m_err = 1;
        end
        m_cnt++;
      end
      if (frame_done) begin
        if (m_cnt == TOTAL) begin
          if (!m_busy) begin
            m_rb = m_wb;
            m_wb = !m_wb;
            m_rdy = 1;
            m_busy = 1;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end else begin
          m_err = 1;
        end
        m_cnt = 0;
      end
    end
  endtask

  initial model_reset();
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // ---------------- compare process + write log ----------------
  int q_bank[$];
  int q_addr[$];
  int q_data[$];

  always @(negedge pclk) begin
    check("mem_we", int'(mem_we), int'(e_we));
    check("mem_bank", int'(mem_bank), int'(e_mb));
    if (mem_we && e_we) begin
      check("mem_addr", int'(mem_addr), e_addr);
      check("mem_wdata", int'(mem_wdata), e_data);
    end
    check("frame_ready", int'(frame_ready), int'(m_rdy));
    check("ready_bank", int'(ready_bank), int'(m_rb));
    check("frame_err", int'(frame_err), int'(m_err));
    check("drop_cnt", int'(drop_cnt), m_drop);
    if (mem_we) begin
      q_bank.push_back(int'(mem_bank));
      q_addr.push_back(int'(mem_addr));
      q_data.push_back(int'(mem_wdata));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit pv, input int pix, input bit fd, input bit ack);
    @(negedge pclk);
    pixel_valid = pv;
    pixel_in    = 12'(pix);
    frame_done  = fd;
    frame_ack   = ack;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic clear_log();
    q_bank.delete(); q_addr.delete(); q_data.delete();
  endtask

  // n pixels base..base+n-1, then frame_done (optionally on the last pixel).
  task automatic frame(input int n, input int base, input bit gaps,
                       input bit last_with_done, input bit ack_at_done);
    int np;
    np = last_with_done ? n - 1 : n;
    for (int i = 0; i < np; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) cyc(0, 0, 0, 0);
      cyc(1, base + i, 0, 0);
    end
    if (last_with_done) cyc(1, base + n - 1, 1, ack_at_done);
    else cyc(0, 0, 1, ack_at_done);
  endtask

  int lit_data[NW];
  int d0;

  initial begin
`ifdef OV7670_DECIMATE_EN
    lit_data = '{0, 2, 4, 6, 16, 18, 20, 22};
`else
    for (int i = 0; i < NW; i++) lit_data[i] = i;
`endif

    // Reset state
    #12;
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_frame_ready", int'(frame_ready), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_frame_err", int'(frame_err), 0);
    @(negedge pclk); @(negedge pclk);
    #2 rst_n = 1'b1;

    // Pixels before the first frame_done are discarded
    clear_log();
    for (int i = 0; i < 5; i++) cyc(1, 12'hA00 + i, 0, 0);
    cyc(0, 0, 1, 0);
    idle(2);
    check("sync_no_writes", q_addr.size(), 0);

    // First complete frame into bank 0
    clear_log();
    frame(32, 0, 1, 0, 0);
    idle(3);
    check("f1_nwrites", q_addr.size(), NW);
    for (int i = 0; i < NW && i < q_addr.size(); i++) begin
      check("f1_bank", q_bank[i], 0);
      check("f1_addr", q_addr[i], i);
      check("f1_data", q_data[i], lit_data[i]);
    end
    check("f1_frame_ready", int'(frame_ready), 1);
    check("f1_ready_bank", int'(ready_bank), 0);
    check("f1_mem_bank", int'(mem_bank), 1);

    // Two further frames, no ack: bank 1 rewritten, swaps blocked
    clear_log();
    frame(32, 12'h100, 1, 0, 0);
    idle(3);
    check("f2_bank", (q_bank.size() > 0) ? q_bank[0] : -1, 1);
    check("f2_drop_cnt", int'(drop_cnt), 1);
    check("f2_ready_bank", int'(ready_bank), 0);
    clear_log();
    frame(32, 12'h200, 1, 0, 0);
    idle(3);
    check("f3_bank_first", (q_bank.size() > 0) ? q_bank[0] : -1, 1);
    check("f3_addr_first", (q_addr.size() > 0) ? q_addr[0] : -1, 0);
    check("f3_ready_bank", int'(ready_bank), 0);

    // Release, then a short frame
    cyc(0, 0, 0, 1);
    idle(2);
    check("ack_clears", int'(frame_ready), 0);
    frame(30, 12'h280, 0, 0, 0);
    idle(2);
    check("short_err", int'(frame_err), 1);
    check("short_no_swap", int'(frame_ready), 0);
    clear_log();
    frame(32, 12'h300, 1, 0, 0);
    idle(3);
    check("after_short_addr0", (q_addr.size() > 0) ? q_addr[0] : -1, 0);
    check("after_short_ready", int'(frame_ready), 1);
    check("after_short_rbank", int'(ready_bank), 1);

    // Ack coincident with completing frame_done, last pixel on frame_done too
    d0 = m_drop;
    clear_log();
    frame(32, 12'h400, 1, 1, 1);
    idle(3);
    check("coinc_ready", int'(frame_ready), 1);
    check("coinc_rbank", int'(ready_bank), 0);
    check("coinc_drop", int'(drop_cnt), d0);
    check("coinc_nwrites", q_addr.size(), NW);

    // Overlong frame: extra pixels not written, no swap
    clear_log();
    frame(34, 12'h500, 0, 0, 0);
    idle(3);
    check("long_nwrites", q_addr.size(), NW);
    check("long_rbank", int'(ready_bank), 0);
    check("long_err", int'(frame_err), 1);

    // Drop counter saturation
    for (int k = 0; k < 260; k++) frame(32, k, 0, 0, 0);
    idle(2);
    check("drop_sat", int'(drop_cnt), 255);

    // Reset mid-frame, after 10 pixels
    for (int i = 0; i < 10; i++) cyc(1, 12'h600 + i, 0, 0);
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", int'(mem_we), 0);
    check("mid_rst_mem_addr", int'(mem_addr), 0);
    check("mid_rst_mem_wdata", int'(mem_wdata), 0);
    check("mid_rst_drop", int'(drop_cnt), 0);
    check("mid_rst_err", int'(frame_err), 0);
    check("mid_rst_ready", int'(frame_ready), 0);
    pixel_valid = 0;
    @(negedge pclk);
    #2 rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 12; i++) cyc(1, 12'h700 + i, 0, 0);
    idle(2);
    check("post_rst_no_write", q_addr.size(), 0);
    cyc(0, 0, 1, 0);
    clear_log();
    frame(32, 12'h800, 1, 0, 0);
    idle(3);
    check("post_rst_nwrites", q_addr.size(), NW);
    check("post_rst_bank", (q_bank.size() > 0) ? q_bank[0] : -1, 0);

    // Randomised frames against the model
    for (int k = 0; k < 60; k++) begin
      int r, n;
      bit lwd;
      r = $urandom_range(0, 6);
      lwd = 0;
      case (r)
        3: n = $urandom_range(1, TOTAL - 1);
        4: n = TOTAL + $urandom_range(1, 3);
        5: begin n = TOTAL; lwd = 1; end
        default: n = TOTAL;
      endcase
      frame(n, $urandom_range(0, 4095), 1, lwd, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 2) == 0) cyc(0, 0, 0, 1);
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
